// File: rtl/error_abs_seq.sv
// Element-wise saturating |x| over a captured N x N signed matrix, LANES per cycle,
// with running max, sticky saturation flag and a threshold convergence flag.
module error_abs_seq #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned FRAC  = 13,
    parameter int unsigned N     = 4,
    parameter int unsigned LANES = 4
) (
    input  logic                     clk_abs,
    input  logic                     rst_abs,
    input  logic                     en_abs,
    input  logic                     start,
    input  logic [WIDTH-1:0]         thresh,
    input  logic [N*N*WIDTH-1:0]     i_mat,
    output logic [N*N*WIDTH-1:0]     o_mat,
    output logic [WIDTH-1:0]         max_abs,
    output logic                     conv,
    output logic                     sat,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned E  = N * N;
    localparam int unsigned NG = E / LANES;
    localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    if ((E % LANES) != 0) begin : g_bad_lanes
        $fatal(1, "error_abs_seq: N*N must be divisible by LANES");
    end
    if (FRAC >= WIDTH) begin : g_bad_frac
        $fatal(1, "error_abs_seq: FRAC must be smaller than WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic                                capture;
    logic                                step;
    logic                                last;
    logic [GW-1:0]                       g_q;
    logic [NG-1:0][LANES-1:0][WIDTH-1:0] mat_q;
    logic [WIDTH-1:0]                    thresh_q;
    logic [WIDTH-1:0]                    max_q;
    logic                                conv_q;
    logic                                sat_q;
    logic                                busy_q;
    logic                                done_q;

    logic [WIDTH-1:0] lane_in  [LANES];
    logic [WIDTH-1:0] lane_abs [LANES];
    logic [WIDTH-1:0] max_chain[LANES+1];
    logic [LANES-1:0] lane_min;
    logic [WIDTH-1:0] max_nxt;
    logic             sat_any;

    // State register
    always_ff @(posedge clk_abs or posedge rst_abs) begin
        if (rst_abs) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state_q;
        capture   = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (en_abs) begin
                    step = 1'b1;
                    if (g_q == GW'(NG - 1)) begin
                        last      = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-lane saturating absolute value of the current group
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l]  = mat_q[g_q][l];
        assign lane_min[l] = (lane_in[l] == MIN_VAL);
        assign lane_abs[l] = lane_min[l]      ? MAX_POS :
                             lane_in[l][WIDTH-1] ? WIDTH'(WIDTH'(0) - lane_in[l]) :
                             lane_in[l];
        assign max_chain[l+1] = (lane_abs[l] > max_chain[l]) ? lane_abs[l] : max_chain[l];
    end

    assign max_chain[0] = max_q;
    assign max_nxt      = max_chain[LANES];
    assign sat_any      = |lane_min;

    // Capture, running max, sticky saturation and convergence
    always_ff @(posedge clk_abs or posedge rst_abs) begin
        if (rst_abs) begin
            g_q      <= '0;
            mat_q    <= '0;
            thresh_q <= '0;
            max_q    <= '0;
            conv_q   <= 1'b0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == S_RUN);
            done_q <= (state_nxt == S_DONE);
            if (capture) begin
                mat_q    <= i_mat;
                thresh_q <= thresh;
                max_q    <= '0;
                sat_q    <= 1'b0;
                conv_q   <= 1'b0;
                g_q      <= '0;
            end else if (step) begin
                max_q <= max_nxt;
                sat_q <= sat_q | sat_any;
                g_q   <= last ? '0 : GW'(g_q + GW'(1));
                if (last) begin
                    conv_q <= (max_nxt <= thresh_q);
                end
            end
        end
    end

    // Result slots: each is written only on the edge that processes its group
    for (genvar g = 0; g < NG; g++) begin : g_grp
        for (genvar l = 0; l < LANES; l++) begin : g_slot
            logic [WIDTH-1:0] o_q;
            always_ff @(posedge clk_abs or posedge rst_abs) begin
                if (rst_abs) begin
                    o_q <= '0;
                end else if (step && (g_q == GW'(g))) begin
                    o_q <= lane_abs[l];
                end
            end
            assign o_mat[(g*LANES + l)*WIDTH +: WIDTH] = o_q;
        end
    end

    assign max_abs = max_q;
    assign conv    = conv_q;
    assign sat     = sat_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_error_abs_seq.sv
// Directed and small random checks of error_abs_seq at three geometries (4x4/4, 3x3/3, 8x8/16).
module tb_error_abs_seq;

    localparam int unsigned W = 26;
    localparam logic [W-1:0] MINV = 26'h2000000;
    localparam logic [W-1:0] MAXP = 26'h1FFFFFF;

    logic clk_abs;
    logic rst_abs;
    logic en_abs;

    logic            st4, cv4, sa4, bz4, dn4;
    logic [W-1:0]    th4, mx4;
    logic [16*W-1:0] im4, om4;

    logic            st3, cv3, sa3, bz3, dn3;
    logic [W-1:0]    th3, mx3;
    logic [9*W-1:0]  im3, om3;

    logic            st8, cv8, sa8, bz8, dn8;
    logic [W-1:0]    th8, mx8;
    logic [64*W-1:0] im8, om8;

    int n_vec;
    int n_err;
    int cyc;
    int bcnt;
    int dcnt;
    logic [16*W-1:0] m;
    logic [W-1:0]    ex [64];
    logic [W-1:0]    emax;
    logic            esat;
    logic [W-1:0]    eth;
    logic [W-1:0]    el;

    error_abs_seq #(.WIDTH(W), .FRAC(13), .N(4), .LANES(4)) dut4 (
        .clk_abs(clk_abs), .rst_abs(rst_abs), .en_abs(en_abs), .start(st4), .thresh(th4),
        .i_mat(im4), .o_mat(om4), .max_abs(mx4), .conv(cv4), .sat(sa4), .busy(bz4), .done(dn4));

    error_abs_seq #(.WIDTH(W), .FRAC(13), .N(3), .LANES(3)) dut3 (
        .clk_abs(clk_abs), .rst_abs(rst_abs), .en_abs(en_abs), .start(st3), .thresh(th3),
        .i_mat(im3), .o_mat(om3), .max_abs(mx3), .conv(cv3), .sat(sa3), .busy(bz3), .done(dn3));

    error_abs_seq #(.WIDTH(W), .FRAC(13), .N(8), .LANES(16)) dut8 (
        .clk_abs(clk_abs), .rst_abs(rst_abs), .en_abs(en_abs), .start(st8), .thresh(th8),
        .i_mat(im8), .o_mat(om8), .max_abs(mx8), .conv(cv8), .sat(sa8), .busy(bz8), .done(dn8));

    initial clk_abs = 1'b0;
    always #5 clk_abs = ~clk_abs;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mabs(input logic [W-1:0] x);
        if (x == MINV) return MAXP;
        if (x[W-1]) return W'(W'(0) - x);
        return x;
    endfunction

    function automatic logic [W-1:0] e4(input int k);
        return om4[k*W +: W];
    endfunction

    // Pulse start on the 4x4 instance; returns at the negedge after the sampling edge
    task automatic start4(input logic [W-1:0] th, input logic [16*W-1:0] mm);
        @(negedge clk_abs);
        im4 = mm;
        th4 = th;
        st4 = 1'b1;
        @(negedge clk_abs);
        st4 = 1'b0;
    endtask

    // Bounded wait for done on the 4x4 instance, counting cycles and busy cycles
    task automatic wait4(input int c0, output int c, output int b);
        c = c0;
        b = 0;
        while (!dn4 && c < 40) begin
            if (bz4) b++;
            @(negedge clk_abs);
            c++;
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_abs = 1'b1;
        en_abs  = 1'b1;
        st4 = 1'b0; th4 = '0; im4 = '0;
        st3 = 1'b0; th3 = '0; im3 = '0;
        st8 = 1'b0; th8 = '0; im8 = '0;
        repeat (3) @(negedge clk_abs);
        rst_abs = 1'b0;

        // Reset state
        for (int k = 0; k < 16; k++) chk("rst_o", e4(k), '0);
        chk("rst_max", mx4, '0);
        chk("rst_conv", W'(cv4), '0);
        chk("rst_sat", W'(sa4), '0);
        chk("rst_busy", W'(bz4), '0);
        chk("rst_done", W'(dn4), '0);

        // 1: all 1.0 in Q13, threshold equal to the max
        for (int k = 0; k < 16; k++) m[k*W +: W] = 26'd8192;
        start4(26'd8192, m);
        wait4(0, cyc, bcnt);
        chk("t1_lat", W'(cyc), 26'd4);
        chk("t1_busy", W'(bcnt), 26'd4);
        for (int k = 0; k < 16; k++) chk("t1_o", e4(k), 26'd8192);
        chk("t1_max", mx4, 26'd8192);
        chk("t1_conv", W'(cv4), 26'd1);
        chk("t1_sat", W'(sa4), 26'd0);
        @(negedge clk_abs);
        chk("t1_done_pulse", W'(dn4), 26'd0);
        chk("t1_busy_off", W'(bz4), 26'd0);

        // 2: negative ramp -(k+1)*100, threshold below the max
        for (int k = 0; k < 16; k++) m[k*W +: W] = W'(-(k + 1) * 100);
        start4(26'd1000, m);
        wait4(0, cyc, bcnt);
        chk("t2_lat", W'(cyc), 26'd4);
        for (int k = 0; k < 16; k++) chk("t2_o", e4(k), W'((k + 1) * 100));
        chk("t2_max", mx4, 26'd1600);
        chk("t2_conv", W'(cv4), 26'd0);
        chk("t2_sat", W'(sa4), 26'd0);

        // 3: most-negative element saturates; unprocessed slots keep old values
        m = '0;
        m[5*W +: W] = MINV;
        start4(26'd0, m);
        @(negedge clk_abs);
        chk("t3_o0_new", e4(0), 26'd0);
        chk("t3_o15_old", e4(15), 26'd1600);
        wait4(1, cyc, bcnt);
        chk("t3_lat", W'(cyc), 26'd4);
        for (int k = 0; k < 16; k++) chk("t3_o", e4(k), (k == 5) ? 26'd33554431 : 26'd0);
        chk("t3_max", mx4, 26'd33554431);
        chk("t3_sat", W'(sa4), 26'd1);
        chk("t3_conv", W'(cv4), 26'd0);

        // 4: ramp again with a 3-cycle stall after the second group, threshold equal to max
        for (int k = 0; k < 16; k++) m[k*W +: W] = W'(-(k + 1) * 100);
        start4(26'd1600, m);
        @(negedge clk_abs);
        @(negedge clk_abs);
        en_abs = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_abs);
            chk("t4_stall_busy", W'(bz4), 26'd1);
            chk("t4_stall_done", W'(dn4), 26'd0);
            chk("t4_stall_o8", e4(8), 26'd0);
        end
        en_abs = 1'b1;
        wait4(5, cyc, bcnt);
        chk("t4_lat", W'(cyc), 26'd7);
        for (int k = 0; k < 16; k++) chk("t4_o", e4(k), W'((k + 1) * 100));
        chk("t4_max", mx4, 26'd1600);
        chk("t4_conv", W'(cv4), 26'd1);
        chk("t4_sat", W'(sa4), 26'd0);

        // 5a: start re-pulsed in RUN (with a different matrix) and in DONE is ignored
        for (int k = 0; k < 16; k++) m[k*W +: W] = W'(k * 10);
        start4(26'd200, m);
        @(negedge clk_abs);
        for (int k = 0; k < 16; k++) im4[k*W +: W] = W'(-7000);
        th4 = '0;
        st4 = 1'b1;
        @(negedge clk_abs);
        st4 = 1'b0;
        wait4(2, cyc, bcnt);
        chk("t5_lat", W'(cyc), 26'd4);
        st4  = 1'b1;
        dcnt = 0;
        @(negedge clk_abs);
        st4 = 1'b0;
        chk("t5_done_ign_busy", W'(bz4), 26'd0);
        for (int s = 0; s < 4; s++) begin
            if (dn4) dcnt++;
            @(negedge clk_abs);
        end
        chk("t5_extra_done", W'(dcnt), 26'd0);
        for (int k = 0; k < 16; k++) chk("t5_o", e4(k), W'(k * 10));
        chk("t5_max", mx4, 26'd150);
        chk("t5_conv", W'(cv4), 26'd1);

        // 5b: reset mid-RUN clears outputs asynchronously, no done, clean rerun
        for (int k = 0; k < 16; k++) m[k*W +: W] = W'(-7000);
        start4(26'd0, m);
        @(negedge clk_abs);
        @(negedge clk_abs);
        rst_abs = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) chk("t5_arst_o", e4(k), '0);
        chk("t5_arst_max", mx4, '0);
        chk("t5_arst_conv", W'(cv4), '0);
        chk("t5_arst_sat", W'(sa4), '0);
        chk("t5_arst_busy", W'(bz4), '0);
        chk("t5_arst_done", W'(dn4), '0);
        @(negedge clk_abs);
        rst_abs = 1'b0;
        dcnt = 0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk_abs);
            if (dn4 || bz4) dcnt++;
        end
        chk("t5_no_done", W'(dcnt), 26'd0);
        start4(26'd0, m);
        wait4(0, cyc, bcnt);
        chk("t5_rerun_lat", W'(cyc), 26'd4);
        for (int k = 0; k < 16; k++) chk("t5_rerun_o", e4(k), 26'd7000);
        chk("t5_rerun_max", mx4, 26'd7000);
        chk("t5_rerun_conv", W'(cv4), 26'd0);

        // 6a: 3x3 with 3 lanes, random vectors against the abs/max model
        for (int t = 0; t < 4; t++) begin
            emax = '0;
            esat = 1'b0;
            for (int k = 0; k < 9; k++) begin
                el = ($urandom_range(0, 3) == 0) ? MINV : W'($urandom);
                im3[k*W +: W] = el;
                ex[k] = mabs(el);
                if (el == MINV) esat = 1'b1;
                if (ex[k] > emax) emax = ex[k];
            end
            eth = (t % 2 == 0) ? emax : W'($urandom);
            th3 = eth;
            @(negedge clk_abs);
            st3 = 1'b1;
            @(negedge clk_abs);
            st3 = 1'b0;
            cyc = 0;
            while (!dn3 && cyc < 40) begin
                @(negedge clk_abs);
                cyc++;
            end
            chk("t6_n3_lat", W'(cyc), 26'd3);
            for (int k = 0; k < 9; k++) chk("t6_n3_o", om3[k*W +: W], ex[k]);
            chk("t6_n3_max", mx3, emax);
            chk("t6_n3_sat", W'(sa3), W'(esat));
            chk("t6_n3_conv", W'(cv3), W'(emax <= eth));
        end

        // 6b: 8x8 with 16 lanes, random vectors against the abs/max model
        for (int t = 0; t < 3; t++) begin
            emax = '0;
            esat = 1'b0;
            for (int k = 0; k < 64; k++) begin
                el = ($urandom_range(0, 15) == 0) ? MINV : W'($urandom);
                im8[k*W +: W] = el;
                ex[k] = mabs(el);
                if (el == MINV) esat = 1'b1;
                if (ex[k] > emax) emax = ex[k];
            end
            eth = (t == 1) ? emax : W'($urandom);
            th8 = eth;
            @(negedge clk_abs);
            st8 = 1'b1;
            @(negedge clk_abs);
            st8 = 1'b0;
            cyc = 0;
            while (!dn8 && cyc < 40) begin
                @(negedge clk_abs);
                cyc++;
            end
            chk("t6_n8_lat", W'(cyc), 26'd4);
            for (int k = 0; k < 64; k++) chk("t6_n8_o", om8[k*W +: W], ex[k]);
            chk("t6_n8_max", mx8, emax);
            chk("t6_n8_sat", W'(sa8), W'(esat));
            chk("t6_n8_conv", W'(cv8), W'(emax <= eth));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
